// File: rtl/if_fetch_icache.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache.
// Hits present in one cycle; misses issue a single word read through the memory controller's fetch port.
module if_fetch_icache #(
  parameter int LINES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mc_req_o,
  output logic [31:0] mc_addr_o,
  input  logic [1:0]  mc_status_i,
  input  logic [31:0] mc_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        if_stall_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;
  // Controller status encoding: Init = 0, Work = 1, Done = 2.
  localparam logic [1:0] MC_DONE = 2'd2;

  typedef enum logic {
    S_LOOKUP = 1'b0,
    S_MISS   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic               inst_valid_q, inst_valid_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [LINES];

  logic [IDX_W-1:0]   lookup_idx;
  logic [IDX_W-1:0]   fill_idx;
  logic               hit;
  logic               in_miss;
  logic               mc_done;
  logic               fill_en;

  assign lookup_idx = pc_q[IDX_W+1:2];
  assign fill_idx   = miss_addr_q[IDX_W+1:2];
  assign hit        = valid_q[lookup_idx] && (tag_q[lookup_idx] == pc_q[31:IDX_W+2]);
  assign in_miss    = (state_q == S_MISS);
  assign mc_done    = (mc_status_i == MC_DONE);

  // The controller samples the request in its Done cycle, so it must drop combinationally there.
  assign mc_req_o     = in_miss && !mc_done && !jump_i;
  assign mc_addr_o    = in_miss ? miss_addr_q : 32'd0;
  assign if_stall_o   = in_miss;
  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    miss_addr_d  = miss_addr_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    inst_valid_d = inst_valid_q;
    valid_d      = valid_q;
    fill_en      = 1'b0;
    case (state_q)
      S_LOOKUP: begin
        if (jump_i) begin
          pc_d         = jump_addr_i;
          inst_valid_d = 1'b0;
        end else if (!stall_i) begin
          if (hit) begin
            inst_d       = data_q[lookup_idx];
            pc_out_d     = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            miss_addr_d  = pc_q;
            inst_valid_d = 1'b0;
            state_d      = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (mc_done) begin
          // Returned data is correct for miss_addr even when a redirect arrives alongside it.
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = S_LOOKUP;
          if (jump_i) begin
            pc_d         = jump_addr_i;
            inst_valid_d = 1'b0;
          end else if (!stall_i) begin
            inst_d       = mc_data_i;
            pc_out_d     = miss_addr_q;
            inst_valid_d = 1'b1;
            pc_d         = miss_addr_q + 32'd4;
          end
        end else if (jump_i) begin
          pc_d         = jump_addr_i;
          inst_valid_d = 1'b0;
          state_d      = S_LOOKUP;
        end
      end
      default: state_d = S_LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOOKUP;
      pc_q         <= 32'd0;
      miss_addr_q  <= 32'd0;
      inst_q       <= 32'd0;
      pc_out_q     <= 32'd0;
      inst_valid_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      miss_addr_q  <= miss_addr_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= miss_addr_q[31:IDX_W+2];
      data_q[fill_idx] <= mc_data_i;
    end
  end

endmodule

// File: doc/if_fetch_icache.md
# if_fetch_icache

Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache. It sits directly upstream of the memory controller's instruction port and directly downstream of the PC redirect logic. It holds the PC, looks up the cache each cycle, and hands instructions to the IF/ID latch. On a miss it drives a word read through the controller's fetch handshake (`if_readwrite` / `if_addr` / `if_status` / `mem_data_o`) and fills the line.

## Interface
- `LINES`, default 128: number of cache lines, a power of two. Index bits are `pc[log2(LINES)+1:2]`; the tag is the remaining upper PC bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  from stall_ctrl; holds PC and outputs.
- `jump_i`  in  1  redirect request, same net as the controller's `ifjump`.
- `jump_addr_i`  in  32  redirect target, word aligned.
- `mc_req_o`  out  1  to controller `if_readwrite`.
- `mc_addr_o`  out  32  to controller `if_addr`.
- `mc_status_i`  in  2  from controller `if_status`, encoded with the shared config macros `Init` / `Work` / `Done`.
- `mc_data_i`  in  32  from controller `mem_data_o`; valid only in a cycle with `mc_status_i == Done`.
- `pc_o`  out  32  PC of `inst_o`.
- `inst_o`  out  32  fetched instruction.
- `inst_valid_o`  out  1  `inst_o` / `pc_o` are a real instruction.
- `if_stall_o`  out  1  to stall_ctrl; high while a miss is outstanding.

## Operation
- **Storage:** per line, 1 valid bit, a tag and a 32-bit data word. All valid bits clear on `rst`.
- **Reset:** state ← LOOKUP, pc ← 0, miss_addr ← 0. Outputs: `pc_o`=0, `inst_o`=0, `inst_valid_o`=0, `mc_req_o`=0, `mc_addr_o`=0, `if_stall_o`=0.
- **State LOOKUP** (first matching rule applies):
  - `jump_i`: pc ← `jump_addr_i`, `inst_valid_o` ← 0.
  - else `stall_i`: hold everything.
  - else hit (valid bit set and tag equal): `inst_o` ← data, `pc_o` ← pc, `inst_valid_o` ← 1, pc ← pc+4.
  - else miss: miss_addr ← pc, `inst_valid_o` ← 0, go to MISS.
- **State MISS:**
  - Combinational outputs: `mc_addr_o` = miss_addr; `mc_req_o` = !(`mc_status_i`==Done) && !`jump_i`; `if_stall_o` = 1.
  - The request is gated off in the Done cycle because the controller samples `if_readwrite` in that same cycle. A registered request would start a spurious second read.
  - The request stays asserted for as long as the controller is busy with data-port traffic, which has priority there. Wait is unbounded.
- **On `mc_status_i` == Done in MISS:**
  - Always write the line at miss_addr's index: valid ← 1, tag, data ← `mc_data_i`.
  - If `!jump_i && !stall_i`: `inst_o` ← `mc_data_i`, `pc_o` ← miss_addr, `inst_valid_o` ← 1, pc ← miss_addr+4.
  - If stalled: fill only, keep pc = miss_addr. The next LOOKUP hits.
  - Go to LOOKUP.
- **`jump_i` in MISS without Done:** abandon the miss (the controller aborts its own read on `ifjump`), pc ← `jump_addr_i`, `inst_valid_o` ← 0, go to LOOKUP. Data from the abandoned read is never written.
- **`jump_i` together with Done:** fill the line (the data is correct for miss_addr), do not present it, redirect as above.
- **`jump_i` priority:** `jump_i` outranks `stall_i` in every state.
- **Outside MISS:** `mc_req_o` = 0, `mc_addr_o` = 0, `if_stall_o` = 0.
- **Arithmetic:** PC increments are 32-bit and wrap from 0xFFFFFFFC to 0x00000000. Bits [1:0] of the PC are ignored for indexing and tagging.

## Timing
- **Hit:** one cycle. Lookup in cycle t; `inst_o` and `inst_valid_o` are registered and visible at t+1. Throughput is 1 instruction per cycle.
- **Miss detected at edge t:** `mc_req_o` high from cycle t+1.
  - With an idle controller: Work at t+2, Done at t+7 (4-byte read, 5 Read cycles), instruction visible at t+8.
  - Total miss penalty is 7 cycles over a hit.
- **`mc_req_o` falls combinationally** in the Done cycle and stays low for at least that cycle.
- **`if_stall_o` timing:** high exactly for the cycles the state is MISS. It drops in the cycle after Done.
- **Stall during LOOKUP:** outputs hold their last values, including `inst_valid_o`.
- **Reset mid-miss:** the block returns to the reset state the following cycle. The controller, sharing `rst`, also returns to Init, so no stale Done can arrive.

## Test plan
- **Cold start:** reset, memory holds 0x00000013 at address 0 and 0x00100093 at address 4, idle controller. Required: `mc_req_o` rises 1 cycle after reset release with `mc_addr_o`=0; `inst_o`=0x00000013, `pc_o`=0 valid 8 cycles later; then a second miss at 4 delivers 0x00100093.
- **Warm loop:** jump to 0 after both words are cached. Required: `pc_o` = 0, 4 on consecutive cycles, `inst_valid_o`=1, `mc_req_o` never asserted.
- **Contention:** the data port holds the controller busy 10 cycles during a miss. Required: `mc_req_o` held high with a constant address, exactly one read issued, `if_stall_o` high throughout.
- **Jump during miss:** `jump_i`=1 to 0x100 while mc status is Work at 0x8. Required: `inst_valid_o` stays 0, line 2 remains invalid, and the next request address is 0x100.
- **Stall at Done:** `stall_i`=1 in the Done cycle for a fill of 0x8. Required: no output change; after the stall releases, a hit delivers 0x8 with no new request.
- **Conflict:** fetch 0x0 then 0x200 (same index with `LINES`=128). Required: the second fetch misses and replaces the line; a refetch of 0x0 misses again.
